// File: rtl/bus_route16_if.sv
// Request/response bundle for bus_route16: CPU master side (m_*) and the 16-way select bus (s_*).
interface bus_route16_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic             m_valid;
    logic             m_write;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata;
    logic             m_ready;
    logic [DW-1:0]    m_rdata;
    logic             m_err;
    logic [15:0]      s_sel;
    logic             s_valid;
    logic             s_write;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [15:0]      s_ready;
    logic [16*DW-1:0] s_rdata;

    // Router side: the issuing end of the select bus.
    modport master (
        input  m_valid, m_write, m_addr, m_wdata, s_ready, s_rdata,
        output m_ready, m_rdata, m_err, s_sel, s_valid, s_write, s_addr, s_wdata
    );

    // Environment side: CPU master plus the peripheral slaves.
    modport slave (
        output m_valid, m_write, m_addr, m_wdata, s_ready, s_rdata,
        input  m_ready, m_rdata, m_err, s_sel, s_valid, s_write, s_addr, s_wdata
    );
endinterface

// File: rtl/bus_route16.sv
// bus_route16: single-master to 16-slave router with a registered one-hot slave select.
// Optional access timeout is compiled in by defining BUS_ROUTE_TIMEOUT_EN.
module bus_route16 #(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter int            SEL_LSB   = 12,
    parameter int            TIMEOUT   = 255,
    parameter logic [DW-1:0] DEF_RDATA = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    bus_route16_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    if (SEL_LSB + 3 >= AW) begin : g_bad_sel_lsb
        $error("bus_route16: SEL_LSB+3 must be below AW");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("bus_route16: TIMEOUT must lie in 1..65535");
    end

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'h0001 << idx;
    endfunction

    state_e        state_q,   state_d;
    logic [15:0]   sel_q,     sel_d;
    logic          s_valid_q, s_valid_d;
    logic          s_write_q, s_write_d;
    logic [AW-1:0] s_addr_q,  s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic          m_ready_q, m_ready_d;
    logic [DW-1:0] m_rdata_q, m_rdata_d;
    logic          m_err_q,   m_err_d;

    logic [3:0]    idx_s;
    logic          hit_s;
    logic          abort_s;
    logic [DW-1:0] slice_s;

    // The latched address picks the slave whose ready and read data matter.
    assign idx_s   = s_addr_q[SEL_LSB+3:SEL_LSB];
    assign hit_s   = bus.s_ready[idx_s];
    assign slice_s = bus.s_rdata[int'(idx_s)*DW +: DW];

`ifdef BUS_ROUTE_TIMEOUT_EN
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Wait counter: held at zero outside ACCESS, so every access starts counting from zero.
    always_comb begin
        wait_cnt_d = 16'd0;
        if (state_q == ST_ACCESS) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = 16'd0;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Abort on the TIMEOUT-th ACCESS edge; a ready arriving on that same edge takes priority.
    assign abort_s = (state_q == ST_ACCESS) && (wait_cnt_q == LAST_WAIT) && !hit_s;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state and registered-output logic for IDLE -> ACCESS -> RESP -> IDLE.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        s_valid_d = s_valid_q;
        s_write_d = s_write_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_ready_d = 1'b0;
        m_rdata_d = m_rdata_q;
        m_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.m_valid) begin
                    s_write_d = bus.m_write;
                    s_addr_d  = bus.m_addr;
                    s_wdata_d = bus.m_wdata;
                    sel_d     = onehot16(bus.m_addr[SEL_LSB+3:SEL_LSB]);
                    s_valid_d = 1'b1;
                    state_d   = ST_ACCESS;
                end else begin
                    sel_d     = 16'h0000;
                    s_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (hit_s || abort_s) begin
                    m_rdata_d = hit_s ? slice_s : DEF_RDATA;
                    m_err_d   = !hit_s;
                    m_ready_d = 1'b1;
                    sel_d     = 16'h0000;
                    s_valid_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    state_d   = ST_ACCESS;
                end
            end
            ST_RESP: begin
                sel_d     = 16'h0000;
                s_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                sel_d     = 16'h0000;
                s_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including mid-access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= 16'h0000;
            s_valid_q <= 1'b0;
            s_write_q <= 1'b0;
            s_addr_q  <= {AW{1'b0}};
            s_wdata_q <= {DW{1'b0}};
            m_ready_q <= 1'b0;
            m_rdata_q <= {DW{1'b0}};
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            s_valid_q <= s_valid_d;
            s_write_q <= s_write_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_ready_q <= m_ready_d;
            m_rdata_q <= m_rdata_d;
            m_err_q   <= m_err_d;
        end
    end

    assign bus.s_sel   = sel_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_write = s_write_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.m_ready = m_ready_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.m_err   = m_err_q;

endmodule

// File: tb/tb_bus_route16.sv
// Self-checking bench for bus_route16: transaction-level model compared every cycle plus directed literal checks.
// Covers the BUS_ROUTE_TIMEOUT_EN build as well as the default build.
module bus_route16_chk (
    input logic        clk,
    input logic        rst,
    input logic [15:0] s_sel,
    input logic        s_valid
);
    a_sel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_sel));
    a_sel_valid:  assert property (@(posedge clk) disable iff (rst) ((s_sel != 16'h0000) == s_valid));
endmodule

module tb_bus_route16;
    localparam int          TO  = 8;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;
`ifdef BUS_ROUTE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    bus_route16_if #(.AW(32), .DW(32)) bus ();

    bus_route16 #(
        .AW(32), .DW(32), .SEL_LSB(12), .TIMEOUT(TO), .DEF_RDATA(DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bus_route16_chk u_chk (.clk(clk), .rst(rst), .s_sel(bus.s_sel), .s_valid(bus.s_valid));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one open access at most, one response cycle after it closes.
    bit          acc_open = 1'b0;
    int          acc_idx = 0;
    int          acc_waits = 0;
    bit          resp_now = 1'b0;
    logic [31:0] resp_data = 32'h0;
    bit          resp_err = 1'b0;
    logic        last_write = 1'b0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_open = 1'b0; resp_now = 1'b0; resp_err = 1'b0; acc_waits = 0;
            last_write = 1'b0; last_addr = 32'h0; last_wdata = 32'h0;
        end else if (resp_now) begin
            resp_now = 1'b0;
            resp_err = 1'b0;
        end else if (acc_open) begin
            acc_waits++;
            if (bus.s_ready[acc_idx]) begin
                resp_now = 1'b1; resp_err = 1'b0; acc_open = 1'b0;
                resp_data = bus.s_rdata[acc_idx*32 +: 32];
            end else if (TO_EN && acc_waits == TO) begin
                resp_now = 1'b1; resp_err = 1'b1; acc_open = 1'b0;
                resp_data = DEF;
            end
        end else if (bus.m_valid) begin
            acc_open   = 1'b1;
            acc_waits  = 0;
            acc_idx    = int'(bus.m_addr[15:12]);
            last_write = bus.m_write;
            last_addr  = bus.m_addr;
            last_wdata = bus.m_wdata;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_ready", bus.m_ready, resp_now);
            chk("m_err", bus.m_err, resp_now & resp_err);
            if (resp_now) chk("m_rdata", bus.m_rdata, resp_data);
            chk("s_sel", bus.s_sel, acc_open ? (16'h0001 << acc_idx) : 16'h0000);
            chk("s_valid", bus.s_valid, acc_open);
            chk("s_write", bus.s_write, last_write);
            chk("s_addr", bus.s_addr, last_addr);
            chk("s_wdata", bus.s_wdata, last_wdata);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget, output int n, output logic [31:0] d, output logic e);
        n = 0;
        while (bus.m_ready !== 1'b1 && n < budget) begin
            cyc(1);
            n++;
        end
        chk("m_ready_seen", bus.m_ready, 1'b1);
        d = bus.m_rdata;
        e = bus.m_err;
    endtask

    task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        bus.m_valid = 1'b1;
        bus.m_write = wr;
        bus.m_addr  = addr;
        bus.m_wdata = wd;
        cyc(1);
    endtask

    int          n;
    logic [31:0] d;
    logic        e;
    bit          seen;

    initial begin
        bus.m_valid = 1'b0; bus.m_write = 1'b0; bus.m_addr = 32'h0; bus.m_wdata = 32'h0;
        bus.s_ready = 16'h0000;
        for (int i = 0; i < 16; i++) bus.s_rdata[i*32 +: 32] = 32'hA500_0000 + i * 32'h0001_0101;
        bus.s_rdata[3*32 +: 32] = 32'hCAFE_F00D;

        cyc(3);
        chk("rst_s_sel", bus.s_sel, 16'h0000);
        chk("rst_s_valid", bus.s_valid, 1'b0);
        chk("rst_m_ready", bus.m_ready, 1'b0);
        chk("rst_m_rdata", bus.m_rdata, 32'h0);
        rst = 1'b0;
        cyc(2);

        // Read slave 3, ready two cycles into the access.
        request(1'b0, 32'h0000_3000, 32'h0);
        chk("rd3_sel", bus.s_sel, 16'h0008);
        chk("rd3_valid", bus.s_valid, 1'b1);
        cyc(1);
        bus.s_ready = 16'h0008;
        wait_ready(10, n, d, e);
        chk("rd3_lat", n, 1);
        chk("rd3_data", d, 32'hCAFE_F00D);
        chk("rd3_err", e, 1'b0);
        chk("rd3_sel_resp", bus.s_sel, 16'h0000);
        bus.m_valid = 1'b0; bus.s_ready = 16'h0000;
        cyc(1);
        chk("rd3_pulse", bus.m_ready, 1'b0);

        // Write slave 15, request fields held while the slave stalls.
        request(1'b1, 32'h0000_F004, 32'h1234_5678);
        chk("wr15_sel", bus.s_sel, 16'h8000);
        chk("wr15_addr", bus.s_addr, 32'h0000_F004);
        chk("wr15_wdata", bus.s_wdata, 32'h1234_5678);
        chk("wr15_write", bus.s_write, 1'b1);
        cyc(5);
        chk("wr15_hold", bus.s_sel, 16'h8000);
        bus.s_ready = 16'h8000;
        wait_ready(10, n, d, e);
        chk("wr15_lat", n, 1);
        chk("wr15_err", e, 1'b0);
        bus.m_valid = 1'b0; bus.s_ready = 16'h0000;
        cyc(1);

        // Ready from the wrong slave must not complete the access.
        request(1'b0, 32'h0000_2010, 32'h0);
        bus.s_ready = 16'h0001;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.m_ready) seen = 1'b1;
        end
        chk("wrong_rdy_done", seen, 1'b0);
        chk("wrong_rdy_sel", bus.s_sel, 16'h0004);
        bus.s_ready = 16'h0005;
        wait_ready(10, n, d, e);
        chk("wrong_rdy_lat", n, 1);
        chk("wrong_rdy_data", d, 32'hA502_0202);
        bus.m_valid = 1'b0; bus.s_ready = 16'h0000;
        cyc(1);

        // Minimum latency: ready already high on the first ACCESS cycle.
        bus.s_ready = 16'hFFFF;
        request(1'b0, 32'h0000_9ABC, 32'h0);
        wait_ready(10, n, d, e);
        chk("lat_min", n, 1);
        chk("lat_data", d, 32'hA509_0909);
        bus.m_valid = 1'b0;
        cyc(1);

        // m_valid held across RESP: the next access starts in the following IDLE cycle.
        request(1'b0, 32'h0000_5000, 32'h0);
        chk("b2b_sel1", bus.s_sel, 16'h0020);
        wait_ready(10, n, d, e);
        chk("b2b_data1", d, 32'hA505_0505);
        bus.m_addr = 32'h0000_6000;
        cyc(1);
        chk("b2b_idle_sel", bus.s_sel, 16'h0000);
        chk("b2b_idle_rdy", bus.m_ready, 1'b0);
        cyc(1);
        chk("b2b_sel2", bus.s_sel, 16'h0040);
        wait_ready(10, n, d, e);
        chk("b2b_data2", d, 32'hA506_0606);
        bus.m_valid = 1'b0;
        cyc(1);

        // Slave 7 never ready.
        bus.s_ready = 16'hFF7F;
        request(1'b0, 32'h0000_7000, 32'h0);
`ifdef BUS_ROUTE_TIMEOUT_EN
        wait_ready(20, n, d, e);
        chk("to_lat", n, TO);
        chk("to_err", e, 1'b1);
        chk("to_data", d, DEF);
        bus.m_valid = 1'b0;
        cyc(1);
        request(1'b0, 32'h0000_7000, 32'h0);
        cyc(3);
`else
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (bus.m_ready) seen = 1'b1;
        end
        chk("noto_done", seen, 1'b0);
        chk("noto_sel", bus.s_sel, 16'h0080);
        chk("noto_err", bus.m_err, 1'b0);
`endif

        // Asynchronous reset in the middle of an access.
        bus.m_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_sel", bus.s_sel, 16'h0000);
        chk("arst_valid", bus.s_valid, 1'b0);
        chk("arst_ready", bus.m_ready, 1'b0);
        chk("arst_addr", bus.s_addr, 32'h0);
        rst = 1'b0;
        cyc(1);

        bus.s_ready = 16'hFFFF;
        request(1'b0, 32'h0000_1000, 32'h0);
        chk("post_rst_sel", bus.s_sel, 16'h0002);
        wait_ready(10, n, d, e);
        chk("post_rst_lat", n, 1);
        chk("post_rst_data", d, 32'hA501_0101);
        bus.m_valid = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
